// File: rtl/iter_divider.sv
// iter_divider: multi-cycle 32-bit signed/unsigned restoring radix-2 divider.
// Produces {remainder, quotient} for the HI/LO path, one quotient bit per cycle.
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

    // Sign fix-up captured at accept; the operands themselves are kept as magnitudes.
    typedef struct packed {
        logic negQuot;
        logic negRem;
    } fixup_t;

    state_t             state, nextState;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;       // {partial remainder, dividend/quotient}
    logic [WIDTH-1:0]   divMag;
    fixup_t             fix;

    logic               accept;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     upper, diff;
    logic [2*WIDTH-1:0] stepAcc;
    logic [WIDTH-1:0]   quoFix, remFix;

    // Operand magnitudes, one restoring step, and sign fix-up of the stepped value.
    always_comb begin
        accept  = (state == IDLE) && start_i && !annul_i;
        mag1    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
        mag2    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
        // Shifted-out carry is kept so unsigned divisors near 2^WIDTH compare correctly.
        upper   = acc[2*WIDTH-1:WIDTH-1];
        diff    = upper - {1'b0, divMag};
        if (!diff[WIDTH])
            stepAcc = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            stepAcc = {acc[2*WIDTH-2:0], 1'b0};
        quoFix  = fix.negQuot ? -stepAcc[WIDTH-1:0] : stepAcc[WIDTH-1:0];
        remFix  = fix.negRem  ? -stepAcc[2*WIDTH-1:WIDTH] : stepAcc[2*WIDTH-1:WIDTH];
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    // Next-state logic; annul wins over completion in ON/DIVZERO, ignored in END.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = (opdata2_i == '0) ? DIVZERO : ON;
            DIVZERO: nextState = annul_i ? IDLE : END;
            ON: begin
                if (annul_i)          nextState = IDLE;
                else if (cnt == LAST) nextState = END;
            end
            END:     if (!start_i) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Datapath, iteration counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            divMag   <= '0;
            fix      <= '0;
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc         <= {{WIDTH{1'b0}}, mag1};
                        divMag      <= mag2;
                        fix.negQuot <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        fix.negRem  <= signed_div_i & opdata1_i[WIDTH-1];
                        cnt         <= '0;
                    end
                end
                DIVZERO: begin
                    if (!annul_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b1;
                    end
                end
                ON: begin
                    if (!annul_i) begin
                        acc <= stepAcc;
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            result_o <= {remFix, quoFix};
                            ready_o  <= 1'b1;
                        end
                    end
                end
                END: begin
                    if (!start_i) ready_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/iter_divider.md
# iter_divider

Multi-cycle 32-bit signed/unsigned integer divider that serves the execute stage's divide requests. The pipeline raises `start_i` and holds it, stalling, until `ready_o` rises. The divider then returns `{remainder, quotient}` for the HI/LO path. It uses restoring radix-2 division, producing one quotient bit per cycle. It lives alongside the ALU in the execute stage.

## Interface
- `WIDTH`, default 32: operand width. The result is `2*WIDTH` bits. Only 32 is required to work.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous and active-low.
- `signed_div_i`  input  1  1 selects signed division, 0 selects unsigned. Latched at accept.
- `opdata1_i`  input  32  dividend. Latched at accept.
- `opdata2_i`  input  32  divisor. Latched at accept.
- `start_i`  input  1  request. The requester holds it high until it has consumed `ready_o`.
- `annul_i`  input  1  aborts an in-flight operation.
- `result_o`  output  64  bits [63:32] hold the remainder (HI); bits [31:0] hold the quotient (LO). Registered.
- `ready_o`  output  1  result valid. Registered.

## Operation
- State machine has four states: IDLE, DIVZERO, ON, END.
- IDLE:
  - If `start_i` is 1 and `annul_i` is 0, accept the request: latch operands and `signed_div_i`, clear the iteration counter.
  - A zero divisor sends the machine to DIVZERO; any other divisor sends it to ON.
  - If `annul_i` is 1, the request is not accepted.
- DIVZERO:
  - Go to END with `result_o` set to 0.
  - If `annul_i` is 1, go to IDLE instead.
- ON:
  - Each cycle runs one restoring step. Shift the 64-bit partial remainder:quotient left by 1, then compare the upper bits with the divisor magnitude. If the upper bits are greater than or equal to the divisor, subtract and set quotient bit = 1; otherwise set it to 0.
  - The counter increments each step. After the 32nd step, apply the sign fix-up, write `result_o` and go to END.
  - If `annul_i` is 1, go to IDLE; `result_o` is unchanged and `ready_o` stays 0.
- END:
  - `ready_o` is 1 and `result_o` is stable.
  - The machine stays in END while `start_i` is 1.
  - When `start_i` is 0, go to IDLE and clear `ready_o`. `result_o` keeps its value until the next completion.
  - `annul_i` is ignored in END.
- Signed mode:
  - Operate on the magnitudes of both operands.
  - Quotient sign is `sign(dividend) XOR sign(divisor)`.
  - Remainder takes the sign of the dividend. A zero result stays zero.
  - The magnitude of 0x80000000 is the unsigned value 2^31.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 (wraps) and remainder 0. No overflow flag is raised.
- Unsigned mode: operands are used as-is and no fix-up is applied.
- Input changes after accept have no effect on the operation in progress.

## Timing
- Reset (`rst` = 0, asynchronous): state goes to IDLE, `ready_o` = 0, `result_o` = 0, counter = 0. This applies in every state, including mid-ON.
- Let T0 be the accept edge.
  - Nonzero divisor: the steps run on edges T0+1 through T0+32. `ready_o` is 1 in the cycle after edge T0+32, i.e. 32 cycles after acceptance.
  - Zero divisor: `ready_o` is 1 after edge T0+1.
- `ready_o` falls on the first edge that samples `start_i` = 0 while in END.
- `start_i` high in END does not start a new operation. A new accept requires one IDLE cycle, so the minimum back-to-back spacing is 34 cycles.
- `annul_i` sampled high at any edge in ON or DIVZERO returns the machine to IDLE on that edge. If `start_i` is still high in IDLE, the request is re-accepted on the next edge.

## Test plan
- Unsigned 100 / 7, `start_i` held: `ready_o` rises exactly 32 cycles after accept, `result_o` = {0x00000002, 0x0000000E}.
- Signed -7 / 2 gives {0xFFFFFFFF, 0xFFFFFFFD}. Signed 7 / -2 gives {0x00000001, 0xFFFFFFFD}. Signed -8 / -2 gives {0x00000000, 0x00000004}.
- 5 / 0, signed and unsigned: `ready_o` after 1 cycle, `result_o` = 0. The previous nonzero result is overwritten.
- Annul at step 10:
  - `ready_o` never rises, state returns to IDLE, `result_o` keeps its prior value.
  - Then unsigned 0xFFFFFFFF / 0x10 gives {0x0000000F, 0x0FFFFFFF}.
- 0x80000000 / 0xFFFFFFFF: signed gives {0x00000000, 0x80000000}; unsigned gives {0x80000000, 0x00000000}.
- Handshake and reset:
  - Hold `start_i` 5 cycles past `ready_o`: `ready_o` and `result_o` stay stable. Drop `start_i`: `ready_o` is 0 after the next edge.
  - Assert `rst` low mid-ON, asynchronously: `ready_o` = 0 and `result_o` = 0 immediately. A request after release completes normally in 32 cycles.
